alu64_seq_ctrl: RTL and testbench
=================================

Name: alu64_seq_ctrl

Overview:
- Sequencer that runs 64-bit operations through the team's existing single-cycle 32-bit ALU (add/sub with carry, and/or/xor, not-A, not-B, pass-A).
- Accepts one command on a valid/ready interface, drives the low word, then the high word with carry/borrow chained between them, and returns a 64-bit result on a second valid/ready interface.
- The ALU instance stays outside this block. This block owns only sequencing, operand/result registers and carry handling.

Parameters:
- ALU_LAT, 0, extra wait cycles between driving the ALU and sampling it (0..3; 0 = combinational ALU).
- OP_W, 4, op-code width; must match the ALU op port.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  OP_W  op code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 not B, others pass A.
- cmd_a  in  64  operand A.
- cmd_b  in  64  operand B.
- cmd_cin  in  1  carry-in (add) or borrow-in (sub); ignored for other ops.
- alu_a  out  32  ALU operand A word.
- alu_b  out  32  ALU operand B word.
- alu_cin  out  1  ALU carry-in.
- alu_op  out  OP_W  ALU op code.
- alu_result  in  32  ALU result.
- alu_cout  in  1  ALU carry/borrow-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  64  result.
- rsp_cout  out  1  final carry (add) or borrow (sub); 0 for all other ops.
- rsp_zero  out  1  result == 0 (see Optional Feature).
- rsp_neg  out  1  result bit 63 (see Optional Feature).

Behaviour:
- Reset (rst high at an edge): state IDLE, wait counter 0.
  - All registered outputs clear to 0: rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_neg, alu_a, alu_b, alu_cin, alu_op.
  - cmd_ready is 0 while rst is high.
- Reset mid-operation aborts the command: no response is produced and the captured data is discarded.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register op, A, B and cin, then go to LO.
  - LO: drive alu_a=A[31:0], alu_b=B[31:0], alu_op=op.
    - alu_cin = cin for op 0/1, else 0.
    - Hold for ALU_LAT cycles, then capture alu_result into result[31:0] and alu_cout into the carry register on the last LO cycle. Go to HI.
  - HI: drive the upper words.
    - alu_cin = captured lo carry for op 0/1, else 0.
    - Same ALU_LAT hold, then capture result[63:32] and the final carry. Go to RSP.
  - RSP: rsp_valid=1 with rsp_result and rsp_cout stable. On rsp_ready, go to IDLE.
- cmd_ready=0 in LO, HI and RSP. Only one command is in flight; there is no cmd-to-rsp bypass.
- Latency: accept edge T → rsp_valid high from cycle T+3+2*ALU_LAT.
  - Minimum initiation interval with rsp_ready tied high is 4+2*ALU_LAT cycles.
  - A response accepted in cycle N allows a new command accept in cycle N+1.
- Carry rules:
  - Sub chains the borrow: HI computes a_hi − b_hi − borrow_lo.
  - rsp_cout=1 means a borrow out of bit 63.
  - For op ≥2, alu_cout is ignored (the ALU does not define it for those ops) and rsp_cout=0.
- Arithmetic wraps modulo 2^64.
- Ops 7..15 return A unchanged.
- rsp_valid stays asserted with a stable payload until the handshake completes (backpressure of any length).
- alu_* outputs hold their last value in IDLE and RSP.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined: rsp_zero=(rsp_result==0) and rsp_neg=rsp_result[63], both registered and valid with rsp_valid.
- Undefined: both ports are tied to 0 and no flag logic is generated.

Decomposition:
- Package alu_seq_pkg holds:
  - op-code constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOTA=5, OP_NOTB=6;
  - the state enum (IDLE, LO, HI, RSP);
  - helper constant IS_ARITH for op 0/1.
- One sub-module is natural: alu_seq_wait_cnt, the ALU_LAT hold counter with load/done outputs.

Test Plan:
- ALU_LAT=0, add A=0x0000_0000_FFFF_FFFF, B=1, cin=0 → result 0x0000_0001_0000_0000, cout 0; rsp_valid at T+3.
- Sub A=0, B=1, cin=0 → result 0xFFFF_FFFF_FFFF_FFFF, cout 1. Then add A=B=0xFFFF_FFFF_FFFF_FFFF, cin=1 → result 0xFFFF_FFFF_FFFF_FFFF, cout 1.
- Xor A=0xF0F0_0000_0000_FFFF, B=0xFFFF_0000_FFFF_0000, with alu_cout forced to 1 → result 0x0F0F_0000_FFFF_FFFF, cout 0. Op 9 with A=0x1234 → result 0x1234.
- rsp_ready low for 5 cycles → rsp_valid and payload stable and cmd_ready=0 throughout; a new command is accepted the cycle after the handshake.
- rst asserted during HI → next edge IDLE, rsp_valid never rises for that command, cmd_ready=1 after rst drops.
- ALU_LAT=2, add 5+7 → result 12, rsp_valid at T+7; with ALU_SEQ_FLAGS_EN, sub 3−3 gives rsp_zero=1, rsp_neg=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared op codes, state encoding and helpers for the 64-bit ALU sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NOTB = 4'd6;

  // One bit per op code; set where the ALU carry/borrow is meaningful.
  localparam logic [15:0] IS_ARITH = (16'd1 << OP_ADD) | (16'd1 << OP_SUB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } seq_state_t;

  function automatic logic is_arith(input int unsigned op);
    logic [3:0] idx;
    idx = op[3:0];
    return (op < 32'd16) && IS_ARITH[idx];
  endfunction

endpackage

// File: rtl/alu_seq_wait_cnt.sv
// ALU latency hold counter: loads LAT, counts down, done at terminal count zero.
module alu_seq_wait_cnt #(
  parameter int unsigned LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [1:0] LAT_INIT = 2'(LAT);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 2'd0;
    else if (load)
      cnt <= LAT_INIT;
    else if (en && !done)
      cnt <= cnt - 2'd1;
  end

  assign done = (cnt == 2'd0);

endmodule

// File: rtl/alu64_seq_ctrl.sv
// Runs 64-bit ops as two passes (low word, then high word) through an external 32-bit ALU.
// Defining ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_neg flags; otherwise they are tied low.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LO    | low words on the ALU; hold ALU_LAT cycles, capture low result and carry
// HI    | high words on the ALU with chained carry/borrow; capture high result
// RSP   | response held on rsp_* until rsp_ready
module alu64_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 0,
  parameter int unsigned OP_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [63:0]     cmd_a,
  input  logic [63:0]     cmd_b,
  input  logic            cmd_cin,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic            alu_cin,
  output logic [OP_W-1:0] alu_op,
  input  logic [31:0]     alu_result,
  input  logic            alu_cout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [63:0]     rsp_result,
  output logic            rsp_cout,
  output logic            rsp_zero,
  output logic            rsp_neg
);

  seq_state_t  state, state_nxt;
  logic        accept, lo_done, hi_done, cnt_load, cnt_en, wait_done;
  logic [31:0] a_hi, b_hi;
  logic        arith;

  alu_seq_wait_cnt #(.LAT(ALU_LAT)) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .done (wait_done)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = LO;
      LO:      if (wait_done) state_nxt = HI;
      HI:      if (wait_done) state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RSP);
    accept    = cmd_valid && cmd_ready;
    lo_done   = (state == LO) && wait_done;
    hi_done   = (state == HI) && wait_done;
    cnt_load  = accept || lo_done;
    cnt_en    = (state == LO) || (state == HI);
  end

  // The ALU ports are loaded one edge ahead so each word is stable for its whole pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_op     <= '0;
      a_hi       <= '0;
      b_hi       <= '0;
      arith      <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= cmd_a[31:0];
        alu_b   <= cmd_b[31:0];
        alu_op  <= cmd_op;
        alu_cin <= is_arith(32'(cmd_op)) && cmd_cin;
        a_hi    <= cmd_a[63:32];
        b_hi    <= cmd_b[63:32];
        arith   <= is_arith(32'(cmd_op));
      end
      if (lo_done) begin
        rsp_result[31:0] <= alu_result;
        alu_a            <= a_hi;
        alu_b            <= b_hi;
        alu_cin          <= arith && alu_cout;
      end
      if (hi_done) begin
        rsp_result[63:32] <= alu_result;
        rsp_cout          <= arith && alu_cout;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (hi_done) begin
      rsp_zero <= (alu_result == 32'd0) && (rsp_result[31:0] == 32'd0);
      rsp_neg  <= alu_result[31];
    end
  end
`else
  assign rsp_zero = 1'b0;
  assign rsp_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu64_seq_ctrl.sv
// Bench for alu64_seq_ctrl: two instances (ALU_LAT 0 and 2) around a behavioural 32-bit ALU,
// checked against a whole-64-bit arithmetic reference model.
`timescale 1ns/1ps
module tb_alu64_seq_ctrl;

  localparam int NDUT = 2;
  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NDUT-1:0] cmd_valid, cmd_ready, cmd_cin, alu_cin, alu_cout;
  logic [NDUT-1:0] rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_neg;
  logic [3:0]      cmd_op     [NDUT];
  logic [3:0]      alu_op     [NDUT];
  logic [63:0]     cmd_a      [NDUT];
  logic [63:0]     cmd_b      [NDUT];
  logic [63:0]     rsp_result [NDUT];
  logic [31:0]     alu_a      [NDUT];
  logic [31:0]     alu_b      [NDUT];
  logic [31:0]     alu_result [NDUT];
  logic            force_cout;

  int n_checks = 0;
  int n_pass   = 0;

  alu64_seq_ctrl #(.ALU_LAT(LAT0), .OP_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_cin(cmd_cin[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_cin(alu_cin[0]), .alu_op(alu_op[0]),
    .alu_result(alu_result[0]), .alu_cout(alu_cout[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_cout(rsp_cout[0]), .rsp_zero(rsp_zero[0]), .rsp_neg(rsp_neg[0])
  );

  alu64_seq_ctrl #(.ALU_LAT(LAT1), .OP_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_cin(cmd_cin[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_cin(alu_cin[1]), .alu_op(alu_op[1]),
    .alu_result(alu_result[1]), .alu_cout(alu_cout[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_cout(rsp_cout[1]), .rsp_zero(rsp_zero[1]), .rsp_neg(rsp_neg[1])
  );

  // External 32-bit ALU; logic ops report force_cout to prove the sequencer ignores it.
  function automatic logic [32:0] alu32(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin, input logic fc);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b} + 33'(cin);
      4'd1:    return {1'b0, a} - {1'b0, b} - 33'(cin);
      4'd2:    return {fc, a & b};
      4'd3:    return {fc, a | b};
      4'd4:    return {fc, a ^ b};
      4'd5:    return {fc, ~a};
      4'd6:    return {fc, ~b};
      default: return {fc, a};
    endcase
  endfunction

  assign {alu_cout[0], alu_result[0]} = alu32(alu_op[0], alu_a[0], alu_b[0], alu_cin[0], force_cout);
  assign {alu_cout[1], alu_result[1]} = alu32(alu_op[1], alu_a[1], alu_b[1], alu_cin[1], force_cout);

  // Reference: {carry/borrow, 64-bit result} computed in one 65-bit step.
  function automatic logic [64:0] ref64(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b} + 65'(cin);
      4'd1:    return {1'b0, a} - {1'b0, b} - 65'(cin);
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, ~a};
      4'd6:    return {1'b0, ~b};
      default: return {1'b0, a};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_cmd(input int d, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic cin, input logic fc, input int stall);
    logic [64:0] exp;
    int lat;
    int n;
    exp = ref64(op, a, b, cin);
    lat = (d == 0) ? LAT0 : LAT1;
    @(negedge clk);
    force_cout   = fc;
    cmd_op[d]    = op;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    cmd_cin[d]   = cin;
    cmd_valid[d] = 1'b1;
    n = 0;
    while (!cmd_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("d%0d_cmd_ready", d), 64'(cmd_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Edges after the accept edge until rsp_valid is visible: 3+2*LAT cycles after accept cycle.
    check($sformatf("d%0d_op%0d_latency", d, op), 64'(n), 64'(2 + 2 * lat));
    check($sformatf("d%0d_op%0d_result", d, op), rsp_result[d], exp[63:0]);
    check($sformatf("d%0d_op%0d_cout", d, op), 64'(rsp_cout[d]), 64'(exp[64]));
`ifdef ALU_SEQ_FLAGS_EN
    check($sformatf("d%0d_zero", d), 64'(rsp_zero[d]), 64'(exp[63:0] == 64'd0));
    check($sformatf("d%0d_neg", d), 64'(rsp_neg[d]), 64'(exp[63]));
`else
    check($sformatf("d%0d_zero", d), 64'(rsp_zero[d]), 64'd0);
    check($sformatf("d%0d_neg", d), 64'(rsp_neg[d]), 64'd0);
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("d%0d_hold_valid", d), 64'(rsp_valid[d]), 64'd1);
      check($sformatf("d%0d_hold_result", d), rsp_result[d], exp[63:0]);
      check($sformatf("d%0d_hold_cout", d), 64'(rsp_cout[d]), 64'(exp[64]));
      check($sformatf("d%0d_hold_busy", d), 64'(cmd_ready[d]), 64'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    check($sformatf("d%0d_ready_after_rsp", d), 64'(cmd_ready[d]), 64'd1);
    check($sformatf("d%0d_valid_drop", d), 64'(rsp_valid[d]), 64'd0);
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 3))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = '0;
    cmd_cin    = '0;
    rsp_ready  = '0;
    force_cout = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      cmd_op[i] = '0;
      cmd_a[i]  = '0;
      cmd_b[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_rst_cmd_ready", d), 64'(cmd_ready[d]), 64'd0);
      check($sformatf("d%0d_rst_rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("d%0d_rst_rsp_result", d), rsp_result[d], 64'd0);
      check($sformatf("d%0d_rst_flags", d), {61'd0, rsp_cout[d], rsp_zero[d], rsp_neg[d]}, 64'd0);
      check($sformatf("d%0d_rst_alu", d), {alu_a[d], alu_b[d]}, 64'd0);
      check($sformatf("d%0d_rst_alu_ctl", d), {59'd0, alu_cin[d], alu_op[d]}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("d0_idle_ready", 64'(cmd_ready[0]), 64'd1);

    run_cmd(0, 4'd0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run_cmd(0, 4'd1, 64'd0, 64'd1, 1'b0, 1'b0, 0);
    run_cmd(0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
    run_cmd(0, 4'd4, 64'hF0F0_0000_0000_FFFF, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1, 0);
    run_cmd(0, 4'd9, 64'h1234, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, 0);
    run_cmd(0, 4'd0, 64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 1'b0, 1'b0, 5);
    run_cmd(0, 4'd1, 64'h5, 64'h3, 1'b0, 1'b0, 0);

    // Abort during the high-word pass.
    @(negedge clk);
    force_cout   = 1'b0;
    cmd_op[0]    = 4'd0;
    cmd_a[0]     = 64'h0000_0005_0000_0003;
    cmd_b[0]     = 64'h0000_0001_0000_0001;
    cmd_cin[0]   = 1'b0;
    cmd_valid[0] = 1'b1;
    check("abort_cmd_ready", 64'(cmd_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    check("abort_lo_word", 64'(alu_a[0]), 64'h3);
    @(posedge clk);
    #1;
    check("abort_hi_word", 64'(alu_a[0]), 64'h5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rst_ready", 64'(cmd_ready[0]), 64'd0);
    check("abort_rst_valid", 64'(rsp_valid[0]), 64'd0);
    check("abort_rst_alu_a", 64'(alu_a[0]), 64'd0);
    check("abort_rst_result", rsp_result[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_after", 64'(cmd_ready[0]), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_rsp", 64'(rsp_valid[0]), 64'd0);
    end

    run_cmd(1, 4'd0, 64'd5, 64'd7, 1'b0, 1'b0, 0);
    run_cmd(1, 4'd1, 64'd3, 64'd3, 1'b0, 1'b0, 2);
    run_cmd(1, 4'd1, 64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(i % 2, 4'($urandom_range(0, 15)), rand64(), rand64(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
